mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single main-memory port between the icache (fetch/prefetch loads) and the dcache
//  (loads and stores). Grants one requester per cycle, forwards its command to memory, returns the
//  memory's accept tag only to the winner, tracks which requester owns each outstanding tag, and
//  routes each completion (mem2proc_tag/data) only to its owner. Sits between the caches and mem.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive icache-losing cycles before icache is forced to win (1..15)
//  NUM_MEM_TAGS  16  memory tag space; tag 0 = "no tag", tags 1..NUM_MEM_TAGS-1 usable
// PORTS
//  clock               in   1   system clock
//  reset               in   1   synchronous, active-high
//  icache_command      in   2   BUS_NONE/BUS_LOAD from icache (BUS_STORE never issued)
//  icache_addr         in   64  icache request address
//  icache_response     out  4   memory accept tag for icache; 0 = rejected/not granted
//  icache_data         out  64  completion data for icache
//  icache_tag          out  4   completion tag for icache; 0 = none this cycle
//  dcache_command      in   2   BUS_NONE/BUS_LOAD/BUS_STORE from dcache
//  dcache_addr         in   64  dcache request address
//  dcache_wr_data      in   64  store data
//  dcache_response     out  4   memory accept tag for dcache; 0 = rejected/not granted
//  dcache_data         out  64  completion data for dcache
//  dcache_tag          out  4   completion tag for dcache; 0 = none this cycle
//  proc2mem_command    out  2   command to memory
//  proc2mem_addr       out  64  address to memory
//  proc2mem_data       out  64  store data to memory
//  mem2proc_response   in   4   memory accept tag (same cycle as command)
//  mem2proc_data       in   64  completion data
//  mem2proc_tag        in   4   completion tag; 0 = none
//  grant_dcache        out  1   1 = dcache owns port this cycle (debug/perf)
//  outstanding_cnt     out  5   number of valid owner-table entries
//  proto_err           out  1   one-cycle pulse: completion for unowned tag, or accept on owned tag
// BEHAVIOUR
//  - Arbitration is combinational on registered state + current commands; zero added latency.
//  - Requesting = command != BUS_NONE. Default priority dcache. Icache wins if dcache idle, or if
//    icache requesting and starve_cnt == STARVE_LIMIT.
//  - starve_cnt (4b): +1 each cycle icache requests but dcache is granted (saturates at limit);
//    cleared when icache granted or icache not requesting. Reset 0.
//  - Winner's command/addr(/data for store) driven to memory; no winner -> BUS_NONE, addr 0, data 0.
//    mem2proc_response routed to winner only; loser's response forced 0 (loser retries next cycle).
//  - Owner table: valid[NUM_MEM_TAGS], owner[NUM_MEM_TAGS] (1=dcache). On accepted LOAD
//    (response != 0): valid[resp]<=1, owner[resp]<=winner. Accepted STOREs do not allocate.
//    Accept on already-valid tag: entry overwritten, proto_err pulses.
//  - Completion: mem2proc_tag != 0 and valid[tag] -> owner's *_tag=mem2proc_tag, *_data=mem2proc_data;
//    other side tag 0, data 0; valid[tag]<=0 next cycle. Tag != 0 and !valid -> dropped, both tags 0,
//    proto_err pulses.
//  - Same-cycle completion and accept on same tag: completion routed by old entry; new accept wins
//    (entry ends valid with new owner); no proto_err.
//  - outstanding_cnt = popcount(valid), registered view (updates the cycle after accept/complete).
//  - While reset high: proc2mem_command BUS_NONE, all responses/tags 0, proto_err 0. On reset the
//    table clears; completions for pre-reset tags arriving afterward are dropped with proto_err.
// TESTING
//  - Only icache LOAD 0x100, mem resp 3 -> icache_response=3, dcache_response=0; later tag 3 + data
//    0xDEAD -> icache_tag=3, icache_data=0xDEAD, dcache_tag=0; outstanding_cnt 1->0.
//  - Both request every cycle, STARVE_LIMIT=4 -> dcache granted 4 cycles, icache granted 5th, repeat.
//  - dcache STORE 0x200 data 0x55, resp 5 -> proc2mem_data=0x55, dcache_response=5, cnt stays 0.
//  - Accept tag 7 to dcache while tag 7 (icache-owned) completes same cycle -> icache_tag=7; next
//    cycle owner[7]=dcache, cnt unchanged, proto_err=0.
//  - mem2proc_tag=9 with no entry -> both *_tag=0, proto_err pulses 1 cycle.
//  - Reset with 3 tags outstanding -> cnt 0 next cycle; their completions dropped, proto_err each.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two caches, the memory port and mem_bus_arbiter.
//   icache_*   : icache request (command/addr) and its accept tag / completion
//   dcache_*   : dcache request (command/addr/wr_data) and its accept tag / completion
//   proc2mem_* : command forwarded to main memory
//   mem2proc_* : memory accept tag (same cycle) and completion tag/data
// modport master : the arbiter's view
// modport slave  : the caches + memory view (environment side)
interface mem_bus_arbiter_if;
    logic [1:0]  icache_command;
    logic [63:0] icache_addr;
    logic [3:0]  icache_response;
    logic [63:0] icache_data;
    logic [3:0]  icache_tag;

    logic [1:0]  dcache_command;
    logic [63:0] dcache_addr;
    logic [63:0] dcache_wr_data;
    logic [3:0]  dcache_response;
    logic [63:0] dcache_data;
    logic [3:0]  dcache_tag;

    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;

    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    modport master (
        input  icache_command, icache_addr,
        input  dcache_command, dcache_addr, dcache_wr_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output icache_response, icache_data, icache_tag,
        output dcache_response, dcache_data, dcache_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data
    );

    modport slave (
        output icache_command, icache_addr,
        output dcache_command, dcache_addr, dcache_wr_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  icache_response, icache_data, icache_tag,
        input  dcache_response, dcache_data, dcache_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single main-memory port between icache and dcache.
// One requester wins per cycle (dcache by default, icache when dcache is idle or
// after STARVE_LIMIT consecutive losing cycles). The winner's command goes to memory
// and only the winner sees the accept tag. An owner table remembers which cache
// issued each outstanding load tag so completions are steered to that cache only.
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   bus             : cache/memory bundle (mem_bus_arbiter_if.master)
//   grant_dcache    : 1 when dcache owns the memory port this cycle
//   outstanding_cnt : number of valid owner-table entries (registered view)
//   proto_err       : pulse on completion for an unowned tag, or accept on an owned tag
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned NUM_MEM_TAGS = 16
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.master bus,
    output logic              grant_dcache,
    output logic [4:0]        outstanding_cnt,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]              starve_cnt;
    logic [NUM_MEM_TAGS-1:0] valid;
    logic [NUM_MEM_TAGS-1:0] owner;     // 1 = dcache

    logic        i_req, d_req;
    logic        grant_i, grant_d;
    logic [1:0]  win_cmd;
    logic        accept, accept_load;
    logic        comp_hit, comp_miss;
    logic        comp_owner_d;
    logic [4:0]  cnt_sum;

    // Arbitration: purely combinational on current commands and registered state.
    always_comb begin
        i_req   = !reset && (bus.icache_command != BUS_NONE);
        d_req   = !reset && (bus.dcache_command != BUS_NONE);
        grant_i = i_req && (!d_req || (starve_cnt == LIMIT));
        grant_d = d_req && !grant_i;

        win_cmd               = BUS_NONE;
        bus.proc2mem_addr     = '0;
        bus.proc2mem_data     = '0;
        if (grant_d) begin
            win_cmd           = bus.dcache_command;
            bus.proc2mem_addr = bus.dcache_addr;
            if (bus.dcache_command == BUS_STORE)
                bus.proc2mem_data = bus.dcache_wr_data;
        end else if (grant_i) begin
            win_cmd           = bus.icache_command;
            bus.proc2mem_addr = bus.icache_addr;
        end
        bus.proc2mem_command = win_cmd;

        // Only the winner sees the accept tag; the loser reads 0 and retries.
        bus.icache_response = grant_i ? bus.mem2proc_response : '0;
        bus.dcache_response = grant_d ? bus.mem2proc_response : '0;
        grant_dcache        = grant_d;

        accept      = (grant_i || grant_d) && (bus.mem2proc_response != '0);
        accept_load = accept && (win_cmd == BUS_LOAD);
    end

    // Completion routing uses the table contents before this cycle's update, so a
    // tag that completes and is re-accepted in the same cycle goes to its old owner.
    always_comb begin
        comp_hit     = !reset && (bus.mem2proc_tag != '0) && valid[bus.mem2proc_tag];
        comp_miss    = !reset && (bus.mem2proc_tag != '0) && !valid[bus.mem2proc_tag];
        comp_owner_d = owner[bus.mem2proc_tag];

        bus.icache_tag  = '0;
        bus.icache_data = '0;
        bus.dcache_tag  = '0;
        bus.dcache_data = '0;
        if (comp_hit) begin
            if (comp_owner_d) begin
                bus.dcache_tag  = bus.mem2proc_tag;
                bus.dcache_data = bus.mem2proc_data;
            end else begin
                bus.icache_tag  = bus.mem2proc_tag;
                bus.icache_data = bus.mem2proc_data;
            end
        end

        // An accept on a tag that is retiring in the same cycle is legitimate reuse.
        proto_err = comp_miss ||
                    (accept && valid[bus.mem2proc_response] &&
                     !(comp_hit && (bus.mem2proc_tag == bus.mem2proc_response)));
    end

    always_comb begin
        cnt_sum = '0;
        for (int unsigned i = 0; i < NUM_MEM_TAGS; i++)
            cnt_sum = cnt_sum + 5'(valid[i]);
    end
    assign outstanding_cnt = cnt_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
            valid      <= '0;
            owner      <= '0;
        end else begin
            if (i_req && grant_d)
                starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            else
                starve_cnt <= '0;

            // Retire first so a same-cycle accept on the same tag wins.
            if (comp_hit)
                valid[bus.mem2proc_tag] <= 1'b0;
            if (accept_load) begin
                valid[bus.mem2proc_response] <= 1'b1;
                owner[bus.mem2proc_response] <= grant_d;
            end
        end
    end

endmodule
